// File: rtl/serv_wb_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : serv_wb_mailbox
// Purpose  : Wishbone mailbox with TX/RX word FIFOs, status, control, scratch.
//            Optional interrupt output enabled by SERV_WB_MAILBOX_IRQ_EN.
// Revision : 1.0
// ============================================================================
module serv_wb_mailbox #(
    parameter int DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_stb,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic [31:0] o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    input  logic [31:0] i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic        o_irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] c_full = CW'(DEPTH);

    logic              r_ack;
    logic [31:0]       r_rdt;
    logic [31:0]       r_tx_mem [DEPTH];
    logic [31:0]       r_rx_mem [DEPTH];
    logic [AW-1:0]     r_tx_rd, r_tx_wr, r_rx_rd, r_rx_wr;
    logic [CW-1:0]     r_tx_cnt, r_rx_cnt;
    logic              r_tx_ovf, r_rx_udf;
    logic [31:0]       r_scratch;

    logic              w_req, w_tx_full, w_rx_full, w_tx_empty, w_rx_empty;
    logic              w_tx_push_req, w_tx_push, w_tx_pop, w_rx_push, w_rx_pop_req, w_rx_pop;
    logic              w_ctrl_wr, w_stat_wr, w_tx_flush, w_rx_flush;
    logic [2:0]        w_adr;
    logic [31:0]       w_mask, w_status, w_ctrl_rd, w_rd_val;
    logic              w_unused;

    assign w_adr      = i_wb_adr[4:2];
    assign w_req      = i_wb_stb & i_wb_cyc & ~r_ack;
    assign w_mask     = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
    assign w_unused   = &{1'b0, i_wb_adr[31:5], i_wb_adr[1:0]};

    assign w_tx_full  = (r_tx_cnt == c_full);
    assign w_rx_full  = (r_rx_cnt == c_full);
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_rx_empty = (r_rx_cnt == '0);

    // Fullness/emptiness are sampled before the cycle, so a same-cycle pop never rescues a push.
    assign w_tx_push_req = w_req & i_wb_we & (w_adr == 3'd0);
    assign w_tx_push     = w_tx_push_req & ~w_tx_full;
    assign w_tx_pop      = ~w_tx_empty & i_tx_ready;
    assign w_rx_push     = i_rx_valid & o_rx_ready;
    assign w_rx_pop_req  = w_req & ~i_wb_we & (w_adr == 3'd0);
    assign w_rx_pop      = w_rx_pop_req & ~w_rx_empty;

    assign w_ctrl_wr  = w_req & i_wb_we & (w_adr == 3'd2);
    assign w_stat_wr  = w_req & i_wb_we & (w_adr == 3'd1) & i_wb_sel[0];
    assign w_tx_flush = w_ctrl_wr & i_wb_sel[0] & i_wb_dat[0];
    assign w_rx_flush = w_ctrl_wr & i_wb_sel[0] & i_wb_dat[1];

    assign o_tx_data  = r_tx_mem[r_tx_rd];
    assign o_tx_valid = ~w_tx_empty;
    assign o_rx_ready = ~i_rst & ~w_rx_full;
    assign o_wb_ack   = r_ack;
    assign o_wb_rdt   = r_rdt;

    always_ff @(posedge i_clk) begin
        if (w_tx_push && !w_tx_flush) r_tx_mem[r_tx_wr] <= i_wb_dat & w_mask;
        if (w_rx_push && !w_rx_flush) r_rx_mem[r_rx_wr] <= i_rx_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || w_tx_flush) begin
            r_tx_rd  <= '0;
            r_tx_wr  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + AW'(1);
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + AW'(1);
            r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || w_rx_flush) begin
            r_rx_rd  <= '0;
            r_rx_wr  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wr <= r_rx_wr + AW'(1);
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + AW'(1);
            r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
        end
    end

    // Sticky flags: the set condition is checked last so it wins over W1C.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_ovf  <= 1'b0;
            r_rx_udf  <= 1'b0;
            r_scratch <= '0;
        end else begin
            if (w_stat_wr && i_wb_dat[2]) r_tx_ovf <= 1'b0;
            if (w_stat_wr && i_wb_dat[3]) r_rx_udf <= 1'b0;
            if (w_tx_push_req && w_tx_full)  r_tx_ovf <= 1'b1;
            if (w_rx_pop_req && w_rx_empty)  r_rx_udf <= 1'b1;
            if (w_req && i_wb_we && (w_adr == 3'd3))
                r_scratch <= (r_scratch & ~w_mask) | (i_wb_dat & w_mask);
        end
    end

`ifdef SERV_WB_MAILBOX_IRQ_EN
    logic r_irq_rx_en, r_irq_txe_en, r_irq;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_irq_rx_en  <= 1'b0;
            r_irq_txe_en <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            if (w_ctrl_wr && i_wb_sel[0]) begin
                r_irq_rx_en  <= i_wb_dat[2];
                r_irq_txe_en <= i_wb_dat[3];
            end
            r_irq <= (r_irq_rx_en & ~w_rx_empty) | (r_irq_txe_en & w_tx_empty);
        end
    end
    assign w_ctrl_rd = {28'h0, r_irq_txe_en, r_irq_rx_en, 2'b00};
    assign o_irq     = r_irq;
`else
    assign w_ctrl_rd = 32'h0;
    assign o_irq     = 1'b0;
`endif

    assign w_status = {8'h00, 8'(r_tx_cnt), 8'(r_rx_cnt), 3'b000,
                       w_tx_empty, r_rx_udf, r_tx_ovf, w_tx_full, ~w_rx_empty};

    always_comb begin
        w_rd_val = 32'h0;
        case (w_adr)
            3'd0:    w_rd_val = w_rx_empty ? 32'h0 : r_rx_mem[r_rx_rd];
            3'd1:    w_rd_val = w_status;
            3'd2:    w_rd_val = w_ctrl_rd;
            3'd3:    w_rd_val = r_scratch;
            default: w_rd_val = 32'h0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack <= 1'b0;
            r_rdt <= '0;
        end else begin
            r_ack <= w_req;
            r_rdt <= (w_req && !i_wb_we) ? w_rd_val : 32'h0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_serv_wb_mailbox.sv
`default_nettype none
// ============================================================================
// Module   : tb_serv_wb_mailbox
// Purpose  : Randomized self-checking bench with a queue-based mailbox model.
// Revision : 1.0
// ============================================================================
module tb_serv_wb_mailbox;
    localparam int DEPTH = 8;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_wb_adr = '0, i_wb_dat = '0, i_rx_data = '0;
    logic [3:0]  i_wb_sel = '0;
    logic        i_wb_we = 1'b0, i_wb_stb = 1'b0, i_wb_cyc = 1'b0;
    logic        i_tx_ready = 1'b0, i_rx_valid = 1'b0;
    logic [31:0] o_wb_rdt, o_tx_data;
    logic        o_wb_ack, o_tx_valid, o_rx_ready, o_irq;

    always #5 i_clk = ~i_clk;

    serv_wb_mailbox #(.DEPTH(DEPTH)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
        .i_wb_we(i_wb_we), .i_wb_stb(i_wb_stb), .i_wb_cyc(i_wb_cyc),
        .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
        .o_irq(o_irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] txq[$];
    logic [31:0] rxq[$];
    bit          m_ovf, m_udf, m_en_rx, m_en_txe, m_irq, m_ack;
    logic [31:0] m_scratch, m_rdt;
    bit          host_rand = 1'b0;

`ifdef SERV_WB_MAILBOX_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    function automatic logic [31:0] m_status();
        logic [31:0] s = '0;
        s[0]     = (rxq.size() != 0);
        s[1]     = (txq.size() == DEPTH);
        s[2]     = m_ovf;
        s[3]     = m_udf;
        s[4]     = (txq.size() == 0);
        s[15:8]  = 8'(rxq.size());
        s[23:16] = 8'(txq.size());
        return s;
    endfunction

    function automatic logic [31:0] m_ctrl();
        return IRQ_ON ? {28'h0, m_en_txe, m_en_rx, 2'b00} : 32'h0;
    endfunction

    // One clock: apply current inputs to the model, advance, then compare.
    task automatic step();
        bit          req, wr, rd, txf, rxf, irq_n;
        logic [2:0]  a;
        logic [31:0] rv, d;
        if (host_rand) begin
            i_tx_ready = 1'($urandom_range(0, 1));
            i_rx_valid = ($urandom_range(0, 2) == 0);
            i_rx_data  = $urandom;
        end
        a = i_wb_adr[4:2];
        d = i_wb_dat;
        if (i_rst) begin
            txq.delete(); rxq.delete();
            m_ovf = 0; m_udf = 0; m_en_rx = 0; m_en_txe = 0; m_irq = 0; m_ack = 0;
            m_scratch = '0; m_rdt = '0;
        end else begin
            req = i_wb_stb && i_wb_cyc && !m_ack;
            wr  = req && i_wb_we;
            rd  = req && !i_wb_we;
            rv  = '0;
            if (rd) begin
                case (a)
                    3'd0:    rv = (rxq.size() != 0) ? rxq[0] : 32'h0;
                    3'd1:    rv = m_status();
                    3'd2:    rv = m_ctrl();
                    3'd3:    rv = m_scratch;
                    default: rv = '0;
                endcase
            end
            irq_n = IRQ_ON && ((m_en_rx && rxq.size() != 0) || (m_en_txe && txq.size() == 0));
            txf = wr && a == 3'd2 && i_wb_sel[0] && d[0];
            rxf = wr && a == 3'd2 && i_wb_sel[0] && d[1];
            if (wr && a == 3'd1 && i_wb_sel[0]) begin
                if (d[2]) m_ovf = 0;
                if (d[3]) m_udf = 0;
            end
            if (txf) txq.delete();
            else begin
                bit pop = (txq.size() != 0) && i_tx_ready;
                bit full = (txq.size() == DEPTH);
                if (pop) void'(txq.pop_front());
                if (wr && a == 3'd0) begin
                    if (full) m_ovf = 1;
                    else txq.push_back(d & {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}},
                                            {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}});
                end
            end
            if (rd && a == 3'd0 && rxq.size() == 0) m_udf = 1;
            if (rxf) rxq.delete();
            else begin
                bit push = i_rx_valid && (rxq.size() < DEPTH);
                if (rd && a == 3'd0 && rxq.size() != 0) void'(rxq.pop_front());
                if (push) rxq.push_back(i_rx_data);
            end
            if (wr && a == 3'd2 && i_wb_sel[0]) begin
                m_en_rx  = d[2];
                m_en_txe = d[3];
            end
            if (wr && a == 3'd3)
                for (int b = 0; b < 4; b++)
                    if (i_wb_sel[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
            m_ack = req;
            m_rdt = rv;
            m_irq = irq_n;
        end
        @(posedge i_clk);
        #1;
        chk("ack", 32'(o_wb_ack), 32'(m_ack));
        chk("rdt", o_wb_rdt, m_rdt);
        chk("tx_valid", 32'(o_tx_valid), 32'(txq.size() != 0));
        if (txq.size() != 0) chk("tx_data", o_tx_data, txq[0]);
        chk("rx_ready", 32'(o_rx_ready), 32'(!i_rst && rxq.size() < DEPTH));
        chk("irq", 32'(o_irq), 32'(m_irq));
    endtask

    // Request cycle, then ack cycle with stb still held, then release.
    task automatic wb(input bit we, input logic [2:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit hpush, input logic [31:0] hdat,
                      output logic [31:0] rd);
        logic [31:0] adr = $urandom;
        adr[4:2] = a;
        i_wb_adr = adr; i_wb_dat = d; i_wb_sel = s; i_wb_we = we;
        i_wb_stb = 1'b1; i_wb_cyc = 1'b1;
        if (hpush) begin i_rx_valid = 1'b1; i_rx_data = hdat; end
        step();
        rd = o_wb_rdt;
        if (hpush) i_rx_valid = 1'b0;
        step();
        i_wb_stb = 1'b0; i_wb_cyc = 1'b0;
    endtask

    task automatic hpush(input logic [31:0] d);
        i_rx_valid = 1'b1; i_rx_data = d;
        step();
        i_rx_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        step(); step();
        chk("rst_rx_ready", 32'(o_rx_ready), 32'h0);
        i_rst = 1'b0;
        step();
        chk("rst_tx_valid", 32'(o_tx_valid), 32'h0);
        chk("rst_rx_ready_after", 32'(o_rx_ready), 32'h1);

        wb(1, 3'd0, 32'hDEADBEEF, 4'hF, 0, 0, r);
        chk("push_head", o_tx_data, 32'hDEADBEEF);
        wb(0, 3'd1, 0, 4'hF, 0, 0, r);
        chk("push_txcnt", 32'(r[23:16]), 32'd1);
        i_tx_ready = 1'b1; step(); i_tx_ready = 1'b0;
        wb(1, 3'd0, 32'h11223344, 4'b0101, 0, 0, r);
        chk("byte_mask", o_tx_data, 32'h00220044);
        wb(1, 3'd2, 32'h1, 4'hF, 0, 0, r);

        for (int i = 0; i < 9; i++) wb(1, 3'd0, 32'h1000 + i, 4'hF, 0, 0, r);
        wb(0, 3'd1, 0, 4'hF, 0, 0, r);
        chk("ovf_txcnt", 32'(r[23:16]), 32'd8);
        chk("ovf_flag", 32'(r[2]), 32'd1);
        chk("ovf_head", o_tx_data, 32'h1000);
        wb(1, 3'd1, 32'h4, 4'hF, 0, 0, r);
        wb(0, 3'd1, 0, 4'hF, 0, 0, r);
        chk("ovf_w1c", 32'(r[2]), 32'd0);
        wb(1, 3'd2, 32'h1, 4'hF, 0, 0, r);

        hpush(32'hA5A5A5A5);
        hpush(32'h12345678);
        wb(0, 3'd0, 0, 4'hF, 0, 0, r); chk("rx_first", r, 32'hA5A5A5A5);
        wb(0, 3'd0, 0, 4'hF, 0, 0, r); chk("rx_second", r, 32'h12345678);
        wb(0, 3'd0, 0, 4'hF, 0, 0, r); chk("rx_empty_read", r, 32'h0);
        wb(0, 3'd1, 0, 4'hF, 0, 0, r); chk("rx_udf", 32'(r[3]), 32'd1);
        wb(1, 3'd1, 32'h8, 4'hF, 0, 0, r);

        hpush(32'h77);
        wb(0, 3'd0, 0, 4'hF, 1, 32'h88, r); chk("rx_pushpop_data", r, 32'h77);
        wb(0, 3'd1, 0, 4'hF, 0, 0, r); chk("rx_pushpop_cnt", 32'(r[15:8]), 32'd1);

        hpush(32'h99); hpush(32'hAA);
        wb(1, 3'd2, 32'h2, 4'hF, 1, 32'hBB, r);
        wb(0, 3'd1, 0, 4'hF, 0, 0, r); chk("flush_rxcnt", 32'(r[15:8]), 32'd0);
        wb(0, 3'd2, 0, 4'hF, 0, 0, r); chk("flush_ctrl", r, 32'h0);

        wb(1, 3'd2, 32'h4, 4'hF, 0, 0, r);
        hpush(32'h55);
        step();
        chk("irq_set", 32'(o_irq), 32'(IRQ_ON));
        wb(0, 3'd0, 0, 4'hF, 0, 0, r);
        chk("irq_clear", 32'(o_irq), 32'h0);
        wb(1, 3'd2, 32'h0, 4'hF, 0, 0, r);

        host_rand = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] d = $urandom;
            logic [3:0]  s = 4'($urandom);
            case ($urandom_range(0, 11))
                0, 1, 2: wb(1, 3'd0, d, s, 0, 0, r);
                3, 4:    wb(0, 3'd0, d, s, 0, 0, r);
                5:       wb(0, 3'd1, d, s, 0, 0, r);
                6:       wb(1, 3'd1, d, s, 0, 0, r);
                7: begin
                    if ($urandom_range(0, 3) != 0) d[1:0] = 2'b00;
                    wb(1, 3'd2, d, s, 0, 0, r);
                end
                8:       wb(1'($urandom), 3'($urandom_range(2, 7)), d, s, 0, 0, r);
                9:       wb(1'($urandom), 3'd3, d, s, 0, 0, r);
                10: begin
                    i_wb_stb = 1'b1; i_wb_cyc = 1'b0; i_wb_we = 1'b1; i_wb_adr = '0;
                    step();
                    i_wb_stb = 1'b0;
                end
                default: begin
                    if ($urandom_range(0, 19) == 0) begin
                        i_wb_adr = d; i_wb_we = 1'($urandom);
                        i_wb_stb = 1'b1; i_wb_cyc = 1'b1; i_rst = 1'b1;
                        step();
                        i_rst = 1'b0; i_wb_stb = 1'b0; i_wb_cyc = 1'b0;
                    end
                    step();
                end
            endcase
        end
        host_rand = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
